// File: rtl/csr_exc_pkg.sv
// Shared types and constants for the exception/ERTN CSR controller.
// Ecode values follow the LoongArch ESTAT.Ecode assignments used by commit.
package csr_exc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    REDIR = 2'd2
  } exc_state_e;

  localparam int PLV_W = 2;

  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_SYS = 6'h0B;
  localparam logic [5:0] ECODE_BRK = 6'h0C;
  localparam logic [5:0] ECODE_INE = 6'h0D;

endpackage

// File: rtl/csr_exc_ctrl_if.sv
// Commit-event and fetch-redirect bundle between the ROB/fetch side and csr_exc_ctrl.
// master = commit/fetch environment, slave = the exception controller.
interface csr_exc_ctrl_if #(
  parameter int NUM_SRC = 2,
  parameter int PC_W    = 32,
  parameter int ECODE_W = 6
);

  logic [NUM_SRC-1:0]         exc_req;
  logic [NUM_SRC*PC_W-1:0]    exc_pc;
  logic [NUM_SRC*ECODE_W-1:0] exc_ecode;
  logic                       ertn_req;
  logic                       redirect_ready;
  logic                       redirect_valid;
  logic [PC_W-1:0]            redirect_pc;

  modport master (
    output exc_req, exc_pc, exc_ecode, ertn_req, redirect_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  exc_req, exc_pc, exc_ecode, ertn_req, redirect_ready,
    output redirect_valid, redirect_pc
  );

endinterface

// File: rtl/exc_prio_sel.sv
// Fixed-priority pick among committing slots: lowest index is oldest and wins.
// Muxes the winning slot's PC and ecode; any_o flags that some slot excepted.
module exc_prio_sel #(
  parameter int NUM_SRC = 2,
  parameter int PC_W    = 32,
  parameter int ECODE_W = 6
) (
  input  logic [NUM_SRC-1:0]         req,
  input  logic [NUM_SRC*PC_W-1:0]    pc,
  input  logic [NUM_SRC*ECODE_W-1:0] ecode,
  output logic [PC_W-1:0]            sel_pc,
  output logic [ECODE_W-1:0]         sel_ecode,
  output logic                       any_o
);

  // Scan from youngest to oldest so the oldest requester overwrites last.
  always_comb begin
    sel_pc    = '0;
    sel_ecode = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        sel_pc    = pc[i*PC_W +: PC_W];
        sel_ecode = ecode[i*ECODE_W +: ECODE_W];
      end
    end
  end

  assign any_o = |req;

endmodule

// File: rtl/csr_exc_ctrl.sv
// Owns ERA, PRMD, CRMD.PLV/IE and ESTAT.Ecode and sequences exception entry / ERTN
// return for an N-wide commit stage: IDLE -> FLUSH (flush pulse) -> REDIR (fetch handshake).
module csr_exc_ctrl
  import csr_exc_pkg::*;
#(
  parameter int              NUM_SRC = 2,
  parameter int              PC_W    = 32,
  parameter int              ECODE_W = 6,
  parameter logic [PC_W-1:0] ERA_RST = '0
) (
  input  logic               clk,
  input  logic               rst,
  csr_exc_ctrl_if.slave      bus,
  input  logic [PC_W-1:0]    eentry,
  input  logic               csrwr_era_en,
  input  logic               csrwr_prmd_en,
  input  logic               csrwr_crmd_en,
  input  logic [PC_W-1:0]    csrwr_data,
  output logic [PC_W-1:0]    era,
  output logic [PLV_W-1:0]   prmd_pplv,
  output logic               prmd_pie,
  output logic [PLV_W-1:0]   crmd_plv,
  output logic               crmd_ie,
  output logic [ECODE_W-1:0] estat_ecode,
  output logic               flush,
  output logic               busy
);

  exc_state_e         state, state_next;
  logic [PC_W-1:0]    sel_pc;
  logic [ECODE_W-1:0] sel_ecode;
  logic               any_exc;
  logic               take_exc;
  logic               take_ertn;

  exc_prio_sel #(
    .NUM_SRC (NUM_SRC),
    .PC_W    (PC_W),
    .ECODE_W (ECODE_W)
  ) u_prio (
    .req       (bus.exc_req),
    .pc        (bus.exc_pc),
    .ecode     (bus.exc_ecode),
    .sel_pc    (sel_pc),
    .sel_ecode (sel_ecode),
    .any_o     (any_exc)
  );

  // Commit events only start a sequence from IDLE; an ERTN alongside an exception is flushed.
  assign take_exc  = (state == IDLE) && any_exc;
  assign take_ertn = (state == IDLE) && bus.ertn_req && !any_exc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (take_exc || take_ertn) state_next = FLUSH;
      FLUSH:   state_next = REDIR;
      REDIR:   if (bus.redirect_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign flush = (state == FLUSH);
  assign busy  = (state != IDLE);

  // Redirect offer is registered so it lines up exactly with the REDIR state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
    end else begin
      bus.redirect_valid <= (state_next == REDIR);
      if (take_exc)       bus.redirect_pc <= eentry;
      else if (take_ertn) bus.redirect_pc <= era;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      era         <= ERA_RST;
      estat_ecode <= '0;
    end else begin
      if (take_exc)          era <= sel_pc;
      else if (csrwr_era_en) era <= csrwr_data;
      if (take_exc)          estat_ecode <= sel_ecode;
    end
  end

  // Hardware capture beats a software write to the same field in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prmd_pplv <= '0;
      prmd_pie  <= 1'b0;
      crmd_plv  <= '0;
      crmd_ie   <= 1'b0;
    end else begin
      if (take_exc) begin
        prmd_pplv <= crmd_plv;
        prmd_pie  <= crmd_ie;
      end else if (csrwr_prmd_en) begin
        prmd_pplv <= csrwr_data[1:0];
        prmd_pie  <= csrwr_data[2];
      end
      if (take_exc) begin
        crmd_plv <= '0;
        crmd_ie  <= 1'b0;
      end else if (take_ertn) begin
        crmd_plv <= prmd_pplv;
        crmd_ie  <= prmd_pie;
      end else if (csrwr_crmd_en) begin
        crmd_plv <= csrwr_data[1:0];
        crmd_ie  <= csrwr_data[2];
      end
    end
  end

endmodule

// File: tb/tb_csr_exc_ctrl.sv
// Directed bench for csr_exc_ctrl: a transaction-level CSR model is compared every
// cycle, and literal checks at key points pin the model itself.
module tb_csr_exc_ctrl;
  import csr_exc_pkg::*;

  localparam int              NUM_SRC = 2;
  localparam int              PC_W    = 32;
  localparam int              ECODE_W = 6;
  localparam logic [PC_W-1:0] ERA_RST = 32'h0000_1000;

  logic               clk = 1'b0;
  logic               rst;
  logic [PC_W-1:0]    eentry;
  logic               csrwr_era_en, csrwr_prmd_en, csrwr_crmd_en;
  logic [PC_W-1:0]    csrwr_data;
  logic [PC_W-1:0]    era;
  logic [1:0]         prmd_pplv, crmd_plv;
  logic               prmd_pie, crmd_ie;
  logic [ECODE_W-1:0] estat_ecode;
  logic               flush, busy;

  int checks = 0;
  int errors = 0;

  csr_exc_ctrl_if #(.NUM_SRC(NUM_SRC), .PC_W(PC_W), .ECODE_W(ECODE_W)) bus ();

  csr_exc_ctrl #(
    .NUM_SRC(NUM_SRC), .PC_W(PC_W), .ECODE_W(ECODE_W), .ERA_RST(ERA_RST)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .eentry(eentry),
    .csrwr_era_en(csrwr_era_en), .csrwr_prmd_en(csrwr_prmd_en),
    .csrwr_crmd_en(csrwr_crmd_en), .csrwr_data(csrwr_data),
    .era(era), .prmd_pplv(prmd_pplv), .prmd_pie(prmd_pie),
    .crmd_plv(crmd_plv), .crmd_ie(crmd_ie), .estat_ecode(estat_ecode),
    .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: architectural CSR values plus a "sequence phase" (0 idle, 1 flushing, 2 redirecting).
  logic [PC_W-1:0]    m_era, m_rpc;
  logic [1:0]         m_pplv, m_plv;
  logic               m_pie, m_ie;
  logic [ECODE_W-1:0] m_ecode;
  int                 m_phase;
  int                 m_k;
  logic               m_exc, m_ertn;

  always_comb begin
    m_k = -1;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (bus.exc_req[i]) m_k = i;
    m_exc  = (m_phase == 0) && (m_k >= 0);
    m_ertn = (m_phase == 0) && (m_k < 0) && bus.ertn_req;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_era <= ERA_RST; m_rpc <= '0; m_pplv <= '0; m_pie <= 1'b0;
      m_plv <= '0; m_ie <= 1'b0; m_ecode <= '0; m_phase <= 0;
    end else begin
      if (m_exc) begin
        m_era   <= bus.exc_pc[m_k*PC_W +: PC_W];
        m_ecode <= bus.exc_ecode[m_k*ECODE_W +: ECODE_W];
        m_pplv  <= m_plv;
        m_pie   <= m_ie;
        m_plv   <= 2'd0;
        m_ie    <= 1'b0;
        m_rpc   <= eentry;
        m_phase <= 1;
      end else begin
        if (csrwr_era_en)  m_era <= csrwr_data;
        if (csrwr_prmd_en) begin m_pplv <= csrwr_data[1:0]; m_pie <= csrwr_data[2]; end
        if (m_ertn) begin
          m_plv   <= m_pplv;
          m_ie    <= m_pie;
          m_rpc   <= m_era;
          m_phase <= 1;
        end else begin
          if (csrwr_crmd_en) begin m_plv <= csrwr_data[1:0]; m_ie <= csrwr_data[2]; end
          if (m_phase == 1) m_phase <= 2;
          else if (m_phase == 2 && bus.redirect_ready) m_phase <= 0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("m_era",   64'(era),                m_era);
    checkOutput("m_pplv",  64'(prmd_pplv),          64'(m_pplv));
    checkOutput("m_pie",   64'(prmd_pie),           64'(m_pie));
    checkOutput("m_plv",   64'(crmd_plv),           64'(m_plv));
    checkOutput("m_ie",    64'(crmd_ie),            64'(m_ie));
    checkOutput("m_ecode", 64'(estat_ecode),        64'(m_ecode));
    checkOutput("m_flush", 64'(flush),              64'(m_phase == 1));
    checkOutput("m_busy",  64'(busy),               64'(m_phase != 0));
    checkOutput("m_rv",    64'(bus.redirect_valid), 64'(m_phase == 2));
    checkOutput("m_rpc",   64'(bus.redirect_pc),    64'(m_rpc));
  end

  // Advance one clock edge and settle just past the following falling edge.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.exc_req = '0; bus.exc_pc = '0; bus.exc_ecode = '0;
    bus.ertn_req = 1'b0; bus.redirect_ready = 1'b1;
    eentry = 32'h1C00_8000;
    csrwr_era_en = 1'b0; csrwr_prmd_en = 1'b0; csrwr_crmd_en = 1'b0; csrwr_data = '0;
    applyStimulus(2);
    rst = 1'b0;
    checkOutput("rst_era",  64'(era), 64'(ERA_RST));
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_rv",   64'(bus.redirect_valid), 64'd0);

    // crmd = PLV3 / IE1
    csrwr_crmd_en = 1'b1; csrwr_data = 32'h7;
    applyStimulus(1);
    csrwr_crmd_en = 1'b0;
    checkOutput("wr_crmd", 64'({crmd_ie, crmd_plv}), 64'h7);

    // Two slots except at once: slot 0 wins.
    bus.exc_req = 2'b11;
    bus.exc_pc = {32'h1C00_0044, 32'h1C00_0040};
    bus.exc_ecode = {ECODE_BRK, ECODE_SYS};
    applyStimulus(1);
    bus.exc_req = 2'b00;
    checkOutput("exc_era",   64'(era), 64'h1C00_0040);
    checkOutput("exc_ecode", 64'(estat_ecode), 64'h0B);
    checkOutput("exc_prmd",  64'({prmd_pie, prmd_pplv}), 64'h7);
    checkOutput("exc_crmd",  64'({crmd_ie, crmd_plv}), 64'h0);
    checkOutput("exc_flush", 64'(flush), 64'd1);
    checkOutput("exc_rv0",   64'(bus.redirect_valid), 64'd0);
    applyStimulus(1);
    checkOutput("exc_flush_end", 64'(flush), 64'd0);
    checkOutput("exc_rv",  64'(bus.redirect_valid), 64'd1);
    checkOutput("exc_rpc", 64'(bus.redirect_pc), 64'h1C00_8000);
    applyStimulus(1);
    checkOutput("exc_idle", 64'(busy), 64'd0);

    // ERTN from era=0x1C00_0100, prmd=3/1, then a stalled redirect.
    csrwr_era_en = 1'b1; csrwr_data = 32'h1C00_0100;
    applyStimulus(1);
    csrwr_era_en = 1'b0;
    bus.ertn_req = 1'b1;
    applyStimulus(1);
    bus.ertn_req = 1'b0;
    bus.redirect_ready = 1'b0;
    checkOutput("ertn_crmd",  64'({crmd_ie, crmd_plv}), 64'h7);
    checkOutput("ertn_flush", 64'(flush), 64'd1);
    bus.exc_req = 2'b01; bus.exc_pc = {32'h0, 32'h2222_0000};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1);
      checkOutput("stall_rv",   64'(bus.redirect_valid), 64'd1);
      checkOutput("stall_rpc",  64'(bus.redirect_pc), 64'h1C00_0100);
      checkOutput("stall_busy", 64'(busy), 64'd1);
      checkOutput("stall_era",  64'(era), 64'h1C00_0100);
    end
    bus.exc_req = 2'b00; bus.redirect_ready = 1'b1;
    applyStimulus(1);
    checkOutput("stall_idle", 64'(busy), 64'd0);

    // Exception capture beats a same-cycle ERA write; the write alone lands next cycle.
    bus.exc_req = 2'b01; bus.exc_pc = {32'h0, 32'h1C00_0200};
    bus.exc_ecode = {ECODE_INT, ECODE_INE};
    csrwr_era_en = 1'b1; csrwr_data = 32'hDEAD_BEEC;
    applyStimulus(1);
    bus.exc_req = 2'b00;
    checkOutput("coll_era", 64'(era), 64'h1C00_0200);
    applyStimulus(1);
    csrwr_era_en = 1'b0;
    checkOutput("wr_era", 64'(era), 64'hDEAD_BEEC);
    applyStimulus(2);

    // Exception on slot 1 together with ERTN: exception path only.
    csrwr_crmd_en = 1'b1; csrwr_data = 32'h5;
    applyStimulus(1);
    csrwr_crmd_en = 1'b0;
    bus.exc_req = 2'b10; bus.exc_pc = {32'h1C00_0300, 32'h0};
    bus.exc_ecode = {ECODE_BRK, ECODE_INT}; bus.ertn_req = 1'b1;
    applyStimulus(1);
    bus.exc_req = 2'b00; bus.ertn_req = 1'b0;
    checkOutput("both_crmd",  64'({crmd_ie, crmd_plv}), 64'h0);
    checkOutput("both_era",   64'(era), 64'h1C00_0300);
    checkOutput("both_ecode", 64'(estat_ecode), 64'h0C);
    checkOutput("both_prmd",  64'({prmd_pie, prmd_pplv}), 64'h5);
    applyStimulus(1);
    checkOutput("both_rpc", 64'(bus.redirect_pc), 64'h1C00_8000);
    applyStimulus(1);

    // Reset while redirect is stalled.
    csrwr_crmd_en = 1'b1; csrwr_data = 32'h6;
    applyStimulus(1);
    csrwr_crmd_en = 1'b0;
    bus.exc_req = 2'b01; bus.exc_pc = {32'h0, 32'h1C00_0400}; bus.redirect_ready = 1'b0;
    applyStimulus(1);
    bus.exc_req = 2'b00;
    applyStimulus(1);
    checkOutput("pre_rst_rv", 64'(bus.redirect_valid), 64'd1);
    rst = 1'b1;
    applyStimulus(1);
    rst = 1'b0;
    bus.redirect_ready = 1'b1;
    checkOutput("mid_rst_rv",   64'(bus.redirect_valid), 64'd0);
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    checkOutput("mid_rst_era",  64'(era), 64'(ERA_RST));
    checkOutput("mid_rst_crmd", 64'({crmd_ie, crmd_plv}), 64'h0);
    applyStimulus(2);
    checkOutput("post_rst_rv", 64'(bus.redirect_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
